// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift-register command sequencer: opcode and FSM state
// encodings plus the direction-pin polarity of the bidirectional shift register.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_SHR_FILL = 2'b00,
        OP_SHL_FILL = 2'b01,
        OP_ROR      = 2'b10,
        OP_ROL      = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_sreg.sv
// Parallel-load, bidirectional shift register driven by shift_seq_ctrl.
// Shifts every clock while load is low; shares the controller's reset.
module shift_seq_sreg
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             serial,
    input  logic             dir,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= pdata;
        end else if (dir == DIR_LEFT) begin
            q <= {q[WIDTH-2:0], serial};
        end else begin
            q <= {serial, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_seq_top.sv
// Integration wrapper: the sequencer wired to its 4-bit shift register, with
// the register contents brought out for observation.
module shift_seq_top
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    logic             sr_load;
    logic             sr_serial;
    logic             sr_dir;
    logic [WIDTH-1:0] sr_pdata;

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_load  (cmd_load),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .cmd_fill  (cmd_fill),
        .sr_load   (sr_load),
        .sr_serial (sr_serial),
        .sr_dir    (sr_dir),
        .sr_pdata  (sr_pdata),
        .sr_q      (q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    shift_seq_sreg #(.WIDTH(WIDTH)) u_sreg (
        .clk    (clk),
        .reset  (reset),
        .load   (sr_load),
        .serial (sr_serial),
        .dir    (sr_dir),
        .pdata  (sr_pdata),
        .q      (q)
    );

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the bidirectional shift register: optional parallel
// load, then N shift/rotate steps, then the final contents on a response channel.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    output logic             sr_load,
    output logic             sr_serial,
    output logic             sr_dir,
    output logic [WIDTH-1:0] sr_pdata,
    input  logic [WIDTH-1:0] sr_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] step_r;
    logic             fill_r;

    // The step counter is primed on every entry into SHIFT, so SHIFT lasts
    // exactly count cycles whether it was entered from IDLE or from LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_r    <= OP_SHR_FILL;
            data_r  <= '0;
            count_r <= '0;
            step_r  <= '0;
            fill_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r    <= op_t'(cmd_op);
                        data_r  <= cmd_data;
                        count_r <= cmd_count;
                        fill_r  <= cmd_fill;
                        step_r  <= cmd_count;
                        if (cmd_load) begin
                            state <= LOAD;
                        end else if (cmd_count != '0) begin
                            state <= SHIFT;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                LOAD: begin
                    step_r <= count_r;
                    state  <= (count_r != '0) ? SHIFT : RESP;
                end
                SHIFT: begin
                    step_r <= step_r - CNT_W'(1);
                    if (step_r == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outside SHIFT the register reloads its own output so its contents hold.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        sr_load   = 1'b1;
        sr_pdata  = sr_q;
        sr_dir    = DIR_RIGHT;
        sr_serial = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        case (state)
            LOAD: begin
                sr_pdata = data_r;
            end
            SHIFT: begin
                sr_load = 1'b0;
                sr_dir  = op_r[0] ? DIR_LEFT : DIR_RIGHT;
                case (op_r)
                    OP_SHR_FILL: sr_serial = fill_r;
                    OP_SHL_FILL: sr_serial = fill_r;
                    OP_ROR:      sr_serial = sr_q[0];
                    OP_ROL:      sr_serial = sr_q[WIDTH-1];
                    default:     sr_serial = 1'b0;
                endcase
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = sr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: controller plus shift register, and the integration
// wrapper driven in parallel, compared against an arithmetic result model.
module tb_shift_seq_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_load, cmd_fill, rsp_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_ready, sr_load, sr_serial, sr_dir, rsp_valid, busy;
    logic [WIDTH-1:0] sr_pdata, sr_q, rsp_data;
    logic             w_cmd_ready, w_rsp_valid, w_busy;
    logic [WIDTH-1:0] w_rsp_data, w_q;

    int checks = 0;
    int failures = 0;
    logic [3:0] held;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_load(cmd_load), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .cmd_fill(cmd_fill), .sr_load(sr_load), .sr_serial(sr_serial), .sr_dir(sr_dir),
        .sr_pdata(sr_pdata), .sr_q(sr_q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    shift_seq_sreg #(.WIDTH(WIDTH)) sreg (
        .clk(clk), .reset(reset), .load(sr_load), .serial(sr_serial), .dir(sr_dir),
        .pdata(sr_pdata), .q(sr_q)
    );

    shift_seq_top #(.WIDTH(WIDTH), .CNT_W(CNT_W)) wrap (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
        .cmd_op(cmd_op), .cmd_load(cmd_load), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .cmd_fill(cmd_fill), .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(w_rsp_data), .busy(w_busy), .q(w_q)
    );

    // Result of a whole command computed in one step from the shift/rotate rules.
    function automatic logic [3:0] model(input logic [1:0] op, input logic ld, input logic [3:0] d,
                                         input int cnt, input logic fill, input logic [3:0] h);
        int v, f, r;
        v = ld ? int'(d) : int'(h);
        f = fill ? 15 : 0;
        r = cnt % 4;
        case (op)
            2'd0: v = (cnt >= 4) ? f : (((v >> cnt) | (f << (4 - cnt))) & 15);
            2'd1: v = (cnt >= 4) ? f : (((v << cnt) | (f >> (4 - cnt))) & 15);
            2'd2: v = ((v >> r) | (v << (4 - r))) & 15;
            default: v = ((v << r) | (v >> (4 - r))) & 15;
        endcase
        return v[3:0];
    endfunction

    // Offers one command and waits for the first cycle with rsp_valid; leaves the response pending.
    task automatic run_cmd(input logic [1:0] op, input logic ld, input logic [3:0] d, input logic [2:0] cnt,
                           input logic fill, output int lat, output logic acc, output logic [3:0] rdata,
                           output logic [3:0] wdata, output logic wvalid);
        acc = cmd_ready & w_cmd_ready;
        cmd_valid = 1'b1; cmd_op = op; cmd_load = ld; cmd_data = d; cmd_count = cnt; cmd_fill = fill;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_data; wdata = w_rsp_data; wvalid = w_rsp_valid;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_load = 1'b0; cmd_data = '0;
        cmd_count = '0; cmd_fill = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({cmd_ready, rsp_valid, busy, sr_load, sr_dir, sr_serial} !== 6'b100100) begin
                failures++;
                $display("FAIL reset_ctrl[%0d] got rdy/vld/busy/ld/dir/ser=%b want 100100", i,
                         {cmd_ready, rsp_valid, busy, sr_load, sr_dir, sr_serial});
            end
            checks++;
            if (rsp_data !== 4'd0 || sr_q !== 4'd0 || sr_pdata !== 4'd0 || w_busy !== 1'b0 || w_q !== 4'd0) begin
                failures++;
                $display("FAIL reset_data[%0d] got rsp=%b q=%b pdata=%b wbusy=%b wq=%b want zeros", i,
                         rsp_data, sr_q, sr_pdata, w_busy, w_q);
            end
            reset = 1'b0;
            @(posedge clk); #1;
        end
        held = 4'd0;
    endtask

    task automatic test_directed();
        logic [1:0] ops[3] = '{2'd0, 2'd3, 2'd2};
        logic [3:0] din[3] = '{4'b1011, 4'b1001, 4'b1101};
        logic [2:0] cnt[3] = '{3'd2, 3'd1, 3'd4};
        logic [3:0] expv[3] = '{4'b0010, 4'b0011, 4'b1101};
        int lat; logic acc, wv; logic [3:0] rd, wd;
        for (int i = 0; i < 3; i++) begin
            run_cmd(ops[i], 1'b1, din[i], cnt[i], 1'b0, lat, acc, rd, wd, wv);
            checks++;
            if (lat !== int'(cnt[i]) + 2 || acc !== 1'b1) begin
                failures++;
                $display("FAIL directed_lat[%0d] got lat=%0d acc=%b want lat=%0d acc=1", i, lat, acc, int'(cnt[i]) + 2);
            end
            checks++;
            if (rd !== expv[i] || sr_q !== expv[i]) begin
                failures++;
                $display("FAIL directed_data[%0d] got rsp=%b q=%b want %b", i, rd, sr_q, expv[i]);
            end
            checks++;
            if (wv !== 1'b1 || wd !== expv[i] || w_q !== expv[i]) begin
                failures++;
                $display("FAIL directed_wrap[%0d] got vld=%b rsp=%b q=%b want 1 %b", i, wv, wd, w_q, expv[i]);
            end
            release_rsp();
            held = expv[i];
        end
    endtask

    task automatic test_hold_idle();
        int lat; logic acc, wv; logic [3:0] rd, wd;
        run_cmd(2'd0, 1'b1, 4'b0110, 3'd0, 1'b1, lat, acc, rd, wd, wv);
        checks++;
        if (lat !== 2 || rd !== 4'b0110) begin
            failures++;
            $display("FAIL hold_setup got lat=%0d rsp=%b want lat=2 rsp=0110", lat, rd);
        end
        release_rsp();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (sr_q !== 4'b0110 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_idle got q=%b busy=%b rdy=%b want 0110 0 1", sr_q, busy, cmd_ready);
        end
        run_cmd(2'($urandom_range(0, 3)), 1'b0, 4'($urandom), 3'd0, 1'b1, lat, acc, rd, wd, wv);
        checks++;
        if (lat !== 1 || rd !== 4'b0110 || wd !== 4'b0110) begin
            failures++;
            $display("FAIL hold_count0 got lat=%0d rsp=%b wrsp=%b want lat=1 rsp=0110", lat, rd, wd);
        end
        release_rsp();
        held = 4'b0110;
    endtask

    task automatic test_fill_sat();
        int lat; logic acc, wv; logic [3:0] rd, wd;
        run_cmd(2'd1, 1'b0, 4'd0, 3'd7, 1'b1, lat, acc, rd, wd, wv);
        checks++;
        if (lat !== 8 || rd !== 4'b1111 || wd !== 4'b1111) begin
            failures++;
            $display("FAIL fill_sat got lat=%0d rsp=%b wrsp=%b want lat=8 rsp=1111", lat, rd, wd);
        end
        release_rsp();
        held = 4'b1111;
    endtask

    task automatic test_backpressure();
        int lat; logic acc, wv; logic [3:0] rd, wd;
        run_cmd(2'd2, 1'b1, 4'b0101, 3'd1, 1'b0, lat, acc, rd, wd, wv);
        checks++;
        if (rd !== 4'b1010) begin
            failures++;
            $display("FAIL bp_first got rsp=%b want 1010", rd);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 4'b1010 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d] got vld=%b rsp=%b rdy=%b busy=%b want 1 1010 0 1", i,
                         rsp_valid, rsp_data, cmd_ready, busy);
            end
            cmd_valid = (i == 2); cmd_load = 1'b1; cmd_data = 4'b1111; cmd_count = 3'd3; cmd_op = 2'd0;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        release_rsp();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || sr_q !== 4'b1010) begin
            failures++;
            $display("FAIL bp_ignored got busy=%b rdy=%b vld=%b q=%b want 0 1 0 1010", busy, cmd_ready, rsp_valid, sr_q);
        end
        held = 4'b1010;
    endtask

    task automatic test_reset_mid();
        int lat; logic acc, wv; logic [3:0] rd, wd;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_load = 1'b1; cmd_data = 4'b1010; cmd_count = 3'd5; cmd_fill = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (sr_load !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_shifting got ld=%b busy=%b want 0 1", sr_load, busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || sr_q !== 4'd0 || w_q !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_idle got busy=%b rdy=%b vld=%b q=%b wq=%b want 0 1 0 0000", busy, cmd_ready,
                     rsp_valid, sr_q, w_q);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        run_cmd(2'd1, 1'b1, 4'b0001, 3'd3, 1'b0, lat, acc, rd, wd, wv);
        checks++;
        if (lat !== 5 || rd !== 4'b1000 || wd !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_after got lat=%0d rsp=%b wrsp=%b want lat=5 rsp=1000", lat, rd, wd);
        end
        release_rsp();
        held = 4'b1000;
    endtask

    task automatic test_random();
        int lat, exp_lat; logic acc, wv; logic [3:0] rd, wd, expv, d;
        logic [1:0] op; logic ld, fill; logic [2:0] cnt;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3)); ld = 1'($urandom); d = 4'($urandom);
            cnt = 3'($urandom_range(0, 7)); fill = 1'($urandom);
            expv = model(op, ld, d, int'(cnt), fill, held);
            exp_lat = int'(cnt) + (ld ? 2 : 1);
            run_cmd(op, ld, d, cnt, fill, lat, acc, rd, wd, wv);
            checks++;
            if (lat !== exp_lat || acc !== 1'b1 || rd !== expv || wv !== 1'b1 || wd !== expv) begin
                failures++;
                $display("FAIL random[%0d] op=%0d ld=%b d=%b cnt=%0d fill=%b got lat=%0d rsp=%b wrsp=%b want lat=%0d rsp=%b",
                         i, op, ld, d, cnt, fill, lat, rd, wd, exp_lat, expv);
            end
            release_rsp();
            held = expv;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold_idle();
        test_fill_sat();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
